// File: rtl/arb_rr_x4.sv
// arb_rr_x4: four-requester round-robin arbiter with registered one-hot grant,
// encoded mux select and an optional per-grant hold limit.
//
// The rotating pointer only moves on a release, and it moves to the slot just
// after the releasing owner. That makes a timed-out owner the lowest-priority
// candidate at its own release edge. A lone timed-out requester is therefore
// re-granted at once, with no idle bubble.
module arb_rr_x4 #(
  parameter int unsigned MAX_HOLD = 16,  // max consecutive grant cycles, 0 = unlimited
  parameter int unsigned CNT_W    = 5    // hold-counter width, 2**CNT_W > MAX_HOLD
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  output logic [3:0] o_grant,
  output logic [1:0] o_sel,
  output logic       o_valid
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam bit               HOLD_EN  = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Registered state and outputs
  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       grant_q;
  logic [1:0]       sel_q;
  logic             valid_q;

  // Combinational arbitration terms
  logic             owner_req_s;
  logic             timeout_s;
  logic             release_s;
  logic [1:0]       ptr_rel_s;
  logic [3:0]       cand_rel_s;
  logic [2:0]       pick_idle_s;
  logic [2:0]       pick_rel_s;
  logic [CNT_W-1:0] cnt_inc_s;

  // Circular search starting at ptr; returns {found, index}. The scan runs
  // from the farthest slot down to ptr, so the slot closest to ptr wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Encoded index to one-hot grant vector
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Release detection and the candidate set for the re-pick at a release edge
  always_comb begin
    owner_req_s = i_req[sel_q];
    timeout_s   = HOLD_EN && (cnt_q == CNT_LAST);
    release_s   = (~owner_req_s) | timeout_s;
    ptr_rel_s   = sel_q + 2'd1;
    cand_rel_s  = i_req;
    if (!owner_req_s) begin
      // Owner gave the resource up; it must not win the same edge.
      cand_rel_s[sel_q] = 1'b0;
    end else begin
      // Timed-out owner stays a candidate, last in the new circular order.
      cand_rel_s = i_req;
    end
    pick_idle_s = rr_pick(i_req, ptr_q);
    pick_rel_s  = rr_pick(cand_rel_s, ptr_rel_s);
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end
  end

  // Arbitration FSM with registered grant, select and valid
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= {CNT_W{1'b0}};
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_idle_s[2]) begin
            state_q <= ST_BUSY;
            grant_q <= onehot4(pick_idle_s[1:0]);
            sel_q   <= pick_idle_s[1:0];
            valid_q <= 1'b1;
            cnt_q   <= {CNT_W{1'b0}};
          end else begin
            state_q <= ST_IDLE;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (!release_s) begin
            cnt_q <= cnt_inc_s;
          end else begin
            ptr_q <= ptr_rel_s;
            if (pick_rel_s[2]) begin
              // Handoff at the same edge: no zero-grant cycle in between.
              state_q <= ST_BUSY;
              grant_q <= onehot4(pick_rel_s[1:0]);
              sel_q   <= pick_rel_s[1:0];
              valid_q <= 1'b1;
              cnt_q   <= {CNT_W{1'b0}};
            end else begin
              // Go idle; o_sel keeps the last owner so the mux stays driven.
              state_q <= ST_IDLE;
              grant_q <= 4'b0000;
              valid_q <= 1'b0;
              cnt_q   <= {CNT_W{1'b0}};
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ptr_q   <= 2'd0;
          cnt_q   <= {CNT_W{1'b0}};
          grant_q <= 4'b0000;
          sel_q   <= 2'd0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant = grant_q;
  assign o_sel   = sel_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_arb_rr_x4.sv
// tb_arb_rr_x4: two arbiters (hold limit 4, and no limit) share one stimulus.
// Each edge's expected outputs come from a behavioural model. The model keeps
// the owner, the rotation start and the number of cycles granted so far. The
// expected values go into one queue per DUT; a monitor pops and compares.
module tb_arb_rr_x4;

  logic       clk;
  logic       i_rst;
  logic [3:0] i_req;
  logic [3:0] g0, g1;
  logic [1:0] s0, s1;
  logic       v0, v1;

  arb_rr_x4 #(.MAX_HOLD(4), .CNT_W(5)) dut0 (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req),
    .o_grant(g0), .o_sel(s0), .o_valid(v0)
  );

  arb_rr_x4 #(.MAX_HOLD(0), .CNT_W(5)) dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req),
    .o_grant(g1), .o_sel(s1), .o_valid(v1)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // Model state per DUT: owner (-1 = none), last owner, rotation start,
  // cycles granted so far and the hold limit.
  int m_owner[2];
  int m_sel[2];
  int m_ptr[2];
  int m_held[2];
  int m_lim[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] req, input int from);
    for (int j = 0; j < 4; j++) begin
      if (req[(from + j) % 4]) return (from + j) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input int k, input logic rst, input logic [3:0] req, output exp_t e);
    int n;
    logic [3:0] cand;
    if (rst) begin
      m_owner[k] = -1; m_sel[k] = 0; m_ptr[k] = 0; m_held[k] = 0;
    end else if (m_owner[k] < 0) begin
      n = pick(req, m_ptr[k]);
      if (n >= 0) begin
        m_owner[k] = n; m_sel[k] = n; m_held[k] = 1;
      end
    end else if (req[m_owner[k]] && !(m_lim[k] != 0 && m_held[k] == m_lim[k])) begin
      m_held[k] = m_held[k] + 1;
    end else begin
      cand = req;
      m_ptr[k] = (m_owner[k] + 1) % 4;
      n = pick(cand, m_ptr[k]);
      if (n >= 0) begin
        m_owner[k] = n; m_sel[k] = n; m_held[k] = 1;
      end else begin
        m_owner[k] = -1; m_held[k] = 0;
      end
    end
    e.grant = (m_owner[k] < 0) ? 4'b0000 : 4'(4'b0001 << m_owner[k]);
    e.sel   = 2'(m_sel[k]);
    e.valid = (m_owner[k] >= 0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc_n, act, exp);
    end
  endtask

  // Apply one cycle of stimulus and record what each DUT must show after the edge
  task automatic drive(input logic rst, input logic [3:0] req);
    exp_t e;
    @(negedge clk);
    i_rst = rst;
    i_req = req;
    cyc_n++;
    model_step(0, rst, req, e);
    q0.push_back(e);
    model_step(1, rst, req, e);
    q1.push_back(e);
  endtask

  task automatic drive_n(input int n, input logic rst, input logic [3:0] req);
    for (int i = 0; i < n; i++) drive(rst, req);
  endtask

  // Monitor: after every active edge, compare each DUT with its queued expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("lim4_grant", int'(g0), int'(e.grant));
      chk("lim4_sel",   int'(s0), int'(e.sel));
      chk("lim4_valid", int'(v0), int'(e.valid));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("nolim_grant", int'(g1), int'(e.grant));
      chk("nolim_sel",   int'(s1), int'(e.sel));
      chk("nolim_valid", int'(v1), int'(e.valid));
    end
  end

  initial begin
    logic [3:0] rq;
    logic       rs;
    m_lim[0] = 4;
    m_lim[1] = 0;
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_sel[k] = 0; m_ptr[k] = 0; m_held[k] = 0;
    end
    i_rst = 1'b1;
    i_req = 4'b0000;

    // Reset with all requests high, then release
    drive_n(3, 1'b1, 4'b1111);
    // Rotation on the limited DUT, lasting ownership on the unlimited one
    drive_n(20, 1'b0, 4'b1111);
    // Single requester grant and drop
    drive_n(1, 1'b1, 4'b0000);
    drive_n(2, 1'b0, 4'b0000);
    drive_n(5, 1'b0, 4'b0100);
    drive_n(3, 1'b0, 4'b0000);
    // Handoff from owner 1 to owner 3 when bit 1 drops
    drive_n(1, 1'b1, 4'b0000);
    drive_n(2, 1'b0, 4'b0010);
    drive_n(2, 1'b0, 4'b1011);
    drive_n(3, 1'b0, 4'b1001);
    drive_n(3, 1'b0, 4'b0000);
    // Lone owner against the hold limit
    drive_n(20, 1'b0, 4'b0100);
    drive_n(2, 1'b0, 4'b0000);
    // Long hold with a mid-grant reset pulse
    drive_n(1, 1'b1, 4'b0000);
    drive_n(50, 1'b0, 4'b1111);
    drive_n(1, 1'b1, 4'b1111);
    drive_n(49, 1'b0, 4'b1111);
    // Random traffic with occasional resets
    rq = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0) rq = 4'($urandom);
      rs = ($urandom_range(63) == 0);
      drive(rs, rq);
    end
    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
